up_down_counter: RTL and testbench

UP_DOWN_COUNTER -- requirements
Module: up_down_counter

---
 rtl/up_down_counter_pkg.sv | 23 ++
 rtl/up_down_counter_prescaler.sv | 36 +++
 rtl/up_down_counter.sv | 89 ++++++++
 tb/tb_up_down_counter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/up_down_counter_pkg.sv
// Shared defaults and parameter legality checks for up_down_counter.
package up_down_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH    = 8;
    localparam int unsigned DEFAULT_PRESCALE = 1;

    function automatic int unsigned max_default(input int unsigned width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

    function automatic bit width_ok(input int unsigned width);
        return (width >= 2) && (width <= 32);
    endfunction

    function automatic bit max_ok(input int unsigned width, input int unsigned max);
        return (max >= 1) && (max <= max_default(width));
    endfunction

    function automatic bit prescale_ok(input int unsigned prescale);
        return (prescale >= 1) && (prescale <= 65535);
    endfunction

endpackage

// File: rtl/up_down_counter_prescaler.sv
// Enable prescaler: tick on every PRESCALE-th enabled cycle; clr or rst restarts the phase.
module cnt_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk2,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] phase_q;
    logic [15:0] phase_d;

    assign tick = en && (phase_q == LAST);

    always_comb begin
        phase_d = phase_q;
        if (clr) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = tick ? '0 : (phase_q + 16'd1);
        end
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/up_down_counter.sv
// Prescaled up/down counter with load and terminal-count pulse.
// Define UP_DOWN_COUNTER_SAT_EN to saturate at the boundaries instead of wrapping.
module up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned MAX      = max_default(WIDTH),
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk2,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    if (!width_ok(WIDTH) || !max_ok(WIDTH, MAX) || !prescale_ok(PRESCALE)) begin : g_bad_params
        $error("up_down_counter: illegal WIDTH/MAX/PRESCALE combination");
    end

    localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             tick;

    cnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk2 (clk2),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (tick)
    );

    // Load wins over a coincident tick and never raises tc.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (tick) begin
            if (up) begin
                if (count_q == MAX_V) begin
                    tc_d = 1'b1;
`ifdef UP_DOWN_COUNTER_SAT_EN
                    count_d = count_q;
`else
                    count_d = '0;
`endif
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (count_q == '0) begin
                    tc_d = 1'b1;
`ifdef UP_DOWN_COUNTER_SAT_EN
                    count_d = count_q;
`else
                    count_d = MAX_V;
`endif
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_up_down_counter.sv
// Directed bench for up_down_counter: WIDTH=4/MAX=9 with PRESCALE=1 (dut_a) and PRESCALE=3 (dut_b).
module tb_up_down_counter;

    logic       clk2;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count_a;
    logic       tc_a;
    logic [3:0] count_b;
    logic       tc_b;

    int checks   = 0;
    int failures = 0;

    up_down_counter #(
        .WIDTH    (4),
        .MAX      (9),
        .PRESCALE (1)
    ) dut_a (
        .clk2     (clk2),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count_a),
        .tc       (tc_a)
    );

    up_down_counter #(
        .WIDTH    (4),
        .MAX      (9),
        .PRESCALE (3)
    ) dut_b (
        .clk2     (clk2),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count_b),
        .tc       (tc_b)
    );

    initial begin
        clk2 = 1'b0;
        forever #5 clk2 = ~clk2;
    end

    task automatic step();
        @(posedge clk2);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Hand-computed vectors for the PRESCALE=1 counting runs.
    int up_cnt [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int up_tc  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int dn_cnt [5]  = '{2, 1, 0, 9, 8};
    int dn_tc  [5]  = '{0, 0, 0, 1, 0};
    int pb_cnt [9]  = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
`ifdef UP_DOWN_COUNTER_SAT_EN
    int sat_cnt [3] = '{9, 9, 9};
    int sat_tc  [3] = '{1, 1, 1};
`else
    int sat_cnt [3] = '{0, 1, 2};
    int sat_tc  [3] = '{1, 0, 0};
`endif

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = 4'd0;
        step();
        check("reset_count_a", 32'(count_a), 0);
        check("reset_tc_a", 32'(tc_a), 0);
        check("reset_count_b", 32'(count_b), 0);

        // Count up through the wrap.
        rst = 1'b0;
        en  = 1'b1;
        up  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("up_count_%0d", i), 32'(count_a), up_cnt[i]);
            check($sformatf("up_tc_%0d", i), 32'(tc_a), up_tc[i]);
        end

        // Load 3 with a coincident tick, then count down through 0.
        load     = 1'b1;
        load_val = 4'd3;
        step();
        check("load3_count", 32'(count_a), 3);
        check("load3_tc", 32'(tc_a), 0);
        load = 1'b0;
        up   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("dn_count_%0d", i), 32'(count_a), dn_cnt[i]);
            check($sformatf("dn_tc_%0d", i), 32'(tc_a), dn_tc[i]);
        end

        // Hold with en low.
        en = 1'b0;
        step();
        step();
        check("hold_count", 32'(count_a), 8);
        check("hold_tc", 32'(tc_a), 0);

        // Clamp load above MAX.
        en       = 1'b1;
        up       = 1'b1;
        load     = 1'b1;
        load_val = 4'd15;
        step();
        check("clamp_count", 32'(count_a), 9);
        check("clamp_tc", 32'(tc_a), 0);

        // Load at MAX with an up tick pending: load only, no wrap, no tc.
        load_val = 4'd9;
        step();
        check("load_at_max_count", 32'(count_a), 9);
        check("load_at_max_tc", 32'(tc_a), 0);

        // Boundary ticks from MAX going up.
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("bound_count_%0d", i), 32'(count_a), sat_cnt[i]);
            check($sformatf("bound_tc_%0d", i), 32'(tc_a), sat_tc[i]);
        end

        // Down from 0.
        load     = 1'b1;
        load_val = 4'd0;
        step();
        load = 1'b0;
        up   = 1'b0;
        step();
`ifdef UP_DOWN_COUNTER_SAT_EN
        check("down_zero_count", 32'(count_a), 0);
`else
        check("down_zero_count", 32'(count_a), 9);
`endif
        check("down_zero_tc", 32'(tc_a), 1);

        // Reset beats load and a boundary tick.
        load     = 1'b1;
        load_val = 4'd9;
        up       = 1'b1;
        step();
        check("pre_rst_count", 32'(count_a), 9);
        rst = 1'b1;
        step();
        check("rst_over_load_count", 32'(count_a), 0);
        check("rst_over_load_tc", 32'(tc_a), 0);

        // PRESCALE=3 run from a clean reset.
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("ps_count_%0d", i), 32'(count_b), pb_cnt[i]);
        end
        check("ps_tc", 32'(tc_b), 0);
        step();
        check("ps_mid_count", 32'(count_b), 3);
        en = 1'b0;
        step();
        step();
        check("ps_paused_count", 32'(count_b), 3);
        en = 1'b1;
        up = 1'b0;
        step();
        check("ps_resume_count", 32'(count_b), 3);
        up = 1'b1;
        step();
        check("ps_delayed_step", 32'(count_b), 4);

        // Reset mid-phase discards the partial phase.
        step();
        rst = 1'b1;
        step();
        check("ps_rst_count", 32'(count_b), 0);
        rst = 1'b0;
        step();
        step();
        check("ps_after_rst_2", 32'(count_b), 0);
        step();
        check("ps_after_rst_3", 32'(count_b), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
